// File: rtl/rob_param_gen2_if.sv
// Handshake bundle between the reorder buffer and its dispatch/complete/retire
// neighbours. The slave modport is the ROB side; the master modport drives it.
interface rob_param_gen2_if #(
    parameter int DEPTH    = 32,
    parameter int DISP_W   = 4,
    parameter int RET_W    = 4,
    parameter int WK_PORTS = 4,
    parameter int SPEC_W   = 4,
    parameter int PAY_W    = 64,
    parameter int ECW      = 5
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DISP_W-1:0]         disp_valid;
    logic [DISP_W*PAY_W-1:0]   disp_payload;
    logic [DISP_W*SPEC_W-1:0]  disp_killmask;
    logic [DISP_W-1:0]         disp_exc;
    logic [DISP_W*ECW-1:0]     disp_ecause;
    logic                      disp_ready;
    logic [DISP_W*IDX_W-1:0]   disp_idx;

    logic [WK_PORTS-1:0]       wk_valid;
    logic [WK_PORTS*IDX_W-1:0] wk_idx;
    logic [WK_PORTS-1:0]       wk_exc;
    logic [WK_PORTS*ECW-1:0]   wk_ecause;

    logic                      br_valid;
    logic                      br_mispred;
    logic [SPEC_W-1:0]         br_tag;
    logic [IDX_W-1:0]          br_idx;

    logic [RET_W-1:0]          ret_valid;
    logic [RET_W*PAY_W-1:0]    ret_payload;
    logic [RET_W-1:0]          ret_exc;
    logic [RET_W*ECW-1:0]      ret_ecause;
    logic                      ret_accept;

    logic [IDX_W:0]            used_cnt;
    logic [IDX_W:0]            free_cnt;

    modport master (
        output disp_valid, disp_payload, disp_killmask, disp_exc, disp_ecause,
        input  disp_ready, disp_idx,
        output wk_valid, wk_idx, wk_exc, wk_ecause,
        output br_valid, br_mispred, br_tag, br_idx,
        input  ret_valid, ret_payload, ret_exc, ret_ecause,
        output ret_accept,
        input  used_cnt, free_cnt
    );

    modport slave (
        input  disp_valid, disp_payload, disp_killmask, disp_exc, disp_ecause,
        output disp_ready, disp_idx,
        input  wk_valid, wk_idx, wk_exc, wk_ecause,
        input  br_valid, br_mispred, br_tag, br_idx,
        output ret_valid, ret_payload, ret_exc, ret_ecause,
        input  ret_accept,
        output used_cnt, free_cnt
    );
endinterface

// File: rtl/rob_param_gen2.sv
// Parameterised reorder buffer: multi-slot dispatch, wakeup ports, branch
// kill/resolve and an in-order retire window of up to RET_W head entries.
// Ports: clk, rst (sync, active high), flush (clear everything), bus (slave
// modport of rob_param_gen2_if: dispatch, wakeup, branch, retire, counts).
// Build option: define ROB_WAKEUP_BYPASS_EN to let an entry woken this cycle
// appear in the retire window the same cycle; otherwise one cycle later.
module rob_param_gen2 #(
    parameter int DEPTH    = 32,
    parameter int DISP_W   = 4,
    parameter int RET_W    = 4,
    parameter int WK_PORTS = 4,
    parameter int SPEC_W   = 4,
    parameter int PAY_W    = 64,
    parameter int ECW      = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    rob_param_gen2_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty differ.
    logic [PW-1:0]     head, tail, n_head, n_tail;
    logic [PW-1:0]     used, free;
    logic              ready;

    logic [DEPTH-1:0]  e_valid, e_busy, e_exc;
    logic [DEPTH-1:0]  n_valid, n_busy, n_exc;
    logic [DEPTH-1:0]  w_busy, w_exc;
    logic [DEPTH-1:0]  v_busy, v_exc;
    logic [DEPTH-1:0]  killed;
    logic [ECW-1:0]    e_ecause [DEPTH];
    logic [ECW-1:0]    n_ecause [DEPTH];
    logic [ECW-1:0]    w_ecause [DEPTH];
    logic [ECW-1:0]    v_ecause [DEPTH];
    logic [SPEC_W-1:0] e_kill   [DEPTH];
    logic [SPEC_W-1:0] n_kill   [DEPTH];
    logic [PAY_W-1:0]  e_pay    [DEPTH];

    logic [IDX_W-1:0]  didx [DISP_W];
    logic [IDX_W-1:0]  rptr [RET_W];
    logic [IDX_W-1:0]  wki  [WK_PORTS];
    logic [IDX_W-1:0]  br_dist;
    logic [SPEC_W-1:0] kclr;
    logic [RET_W-1:0]  rv;
    logic              run;
    logic              mispred, resolve, disp_fire;
    logic [PW-1:0]     disp_cnt, ret_cnt;

    assign used    = tail - head;
    assign free    = PW'(DEPTH) - used;
    assign ready   = free >= PW'(DISP_W);
    assign mispred = bus.br_valid & bus.br_mispred;
    assign resolve = bus.br_valid & ~bus.br_mispred;
    assign kclr    = resolve ? bus.br_tag : '0;
    assign br_dist = bus.br_idx - head[IDX_W-1:0];

    assign disp_fire = ready & (|bus.disp_valid) & ~flush & ~mispred & ~rst;

    assign bus.disp_ready = ready;
    assign bus.used_cnt   = used;
    assign bus.free_cnt   = free;
    assign bus.ret_valid  = rv;

    for (genvar i = 0; i < DISP_W; i++) begin : g_disp
        assign didx[i] = tail[IDX_W-1:0] + IDX_W'(i);
        assign bus.disp_idx[i*IDX_W +: IDX_W] = didx[i];
    end

    for (genvar p = 0; p < WK_PORTS; p++) begin : g_wk
        assign wki[p] = bus.wk_idx[p*IDX_W +: IDX_W];
    end

    // Post-wakeup view. Ports are walked high to low so the lowest
    // port is the last writer and wins on a shared target.
    always_comb begin
        w_busy   = e_busy;
        w_exc    = e_exc;
        w_ecause = e_ecause;
        for (int p = WK_PORTS - 1; p >= 0; p--) begin
            if (bus.wk_valid[p] && e_valid[wki[p]]) begin
                w_busy[wki[p]] = 1'b0;
                if (!e_exc[wki[p]]) begin
                    w_exc[wki[p]]    = bus.wk_exc[p];
                    w_ecause[wki[p]] = bus.wk_ecause[p*ECW +: ECW];
                end
            end
        end
    end

`ifdef ROB_WAKEUP_BYPASS_EN
    assign v_busy   = w_busy;
    assign v_exc    = w_exc;
    assign v_ecause = w_ecause;
`else
    assign v_busy   = e_busy;
    assign v_exc    = e_exc;
    assign v_ecause = e_ecause;
`endif

    always_comb begin
        killed = '0;
        for (int d = 0; d < DEPTH; d++) begin
            killed[d] = mispred & e_valid[d] & (|(e_kill[d] & bus.br_tag));
        end
    end

    for (genvar k = 0; k < RET_W; k++) begin : g_ret
        assign rptr[k] = head[IDX_W-1:0] + IDX_W'(k);
        assign bus.ret_payload[k*PAY_W +: PAY_W] = e_pay[rptr[k]];
        assign bus.ret_exc[k] = v_exc[rptr[k]];
        assign bus.ret_ecause[k*ECW +: ECW] = v_ecause[rptr[k]];
    end

    // Thermometer window: stops at the first not-ready entry and
    // right after the first excepting one.
    always_comb begin
        rv  = '0;
        run = 1'b1;
        for (int k = 0; k < RET_W; k++) begin
            if (run && (PW'(k) < used) && e_valid[rptr[k]] &&
                !v_busy[rptr[k]] && !killed[rptr[k]]) begin
                rv[k] = 1'b1;
                run   = ~v_exc[rptr[k]];
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        n_valid  = e_valid;
        n_busy   = w_busy;
        n_exc    = w_exc;
        n_ecause = w_ecause;
        n_kill   = e_kill;
        ret_cnt  = '0;
        disp_cnt = '0;
        n_tail   = tail;
        if (bus.ret_accept) begin
            for (int k = 0; k < RET_W; k++) begin
                if (rv[k]) begin
                    n_valid[rptr[k]] = 1'b0;
                    ret_cnt = ret_cnt + PW'(1);
                end
            end
        end
        n_head = head + ret_cnt;
        if (mispred) begin
            n_valid = n_valid & ~killed;
            n_tail  = head + PW'(br_dist) + PW'(1);
        end else begin
            for (int d = 0; d < DEPTH; d++) begin
                n_kill[d] = e_kill[d] & ~kclr;
            end
            if (disp_fire) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (bus.disp_valid[i]) begin
                        n_valid[didx[i]]  = 1'b1;
                        n_busy[didx[i]]   = ~bus.disp_exc[i];
                        n_exc[didx[i]]    = bus.disp_exc[i];
                        n_ecause[didx[i]] = bus.disp_ecause[i*ECW +: ECW];
                        n_kill[didx[i]]   =
                            bus.disp_killmask[i*SPEC_W +: SPEC_W] & ~kclr;
                        disp_cnt = disp_cnt + PW'(1);
                    end
                end
            end
            n_tail = tail + disp_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            e_valid <= '0;
            e_busy  <= '0;
            e_exc   <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                e_ecause[d] <= '0;
                e_kill[d]   <= '0;
            end
        end else begin
            head     <= n_head;
            tail     <= n_tail;
            e_valid  <= n_valid;
            e_busy   <= n_busy;
            e_exc    <= n_exc;
            e_ecause <= n_ecause;
            e_kill   <= n_kill;
        end
    end

    // Payload needs no reset: it is only visible behind a valid entry.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (bus.disp_valid[i]) begin
                    e_pay[didx[i]] <= bus.disp_payload[i*PAY_W +: PAY_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_param_gen2.sv
// Self-checking bench for rob_param_gen2: expected payloads are queued at
// dispatch and compared in order as the retire window hands them back.
module tb_rob_param_gen2;
    localparam int DEPTH    = 32;
    localparam int DISP_W   = 4;
    localparam int RET_W    = 4;
    localparam int WK_PORTS = 4;
    localparam int SPEC_W   = 4;
    localparam int PAY_W    = 64;
    localparam int ECW      = 5;
    localparam int IDX_W    = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    rob_param_gen2_if #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .RET_W(RET_W), .WK_PORTS(WK_PORTS),
        .SPEC_W(SPEC_W), .PAY_W(PAY_W), .ECW(ECW)
    ) bus ();

    rob_param_gen2 #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .RET_W(RET_W), .WK_PORTS(WK_PORTS),
        .SPEC_W(SPEC_W), .PAY_W(PAY_W), .ECW(ECW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [PAY_W-1:0] exp_q[$];
    logic [PAY_W-1:0] e;
    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;
    int m_used   = 0;
    int m_tail   = 0;

    task automatic idle();
        bus.disp_valid    = '0;
        bus.disp_payload  = '0;
        bus.disp_killmask = '0;
        bus.disp_exc      = '0;
        bus.disp_ecause   = '0;
        bus.wk_valid      = '0;
        bus.wk_idx        = '0;
        bus.wk_exc        = '0;
        bus.wk_ecause     = '0;
        bus.br_valid      = 1'b0;
        bus.br_mispred    = 1'b0;
        bus.br_tag        = '0;
        bus.br_idx        = '0;
        bus.ret_accept    = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n dispatch slots; the model pushes them only if it expects
    // the ROB to accept (take=0 for cycles that must drop dispatch).
    task automatic drive_disp(input int n, input logic [SPEC_W-1:0] km,
                              input logic ex, input logic [ECW-1:0] ec,
                              input bit take);
        logic [PAY_W-1:0] p;
        bit acc;
        acc = take && (n > 0) && ((DEPTH - m_used) >= DISP_W);
        for (int i = 0; i < n; i++) begin
            p = {32'hC0DE_0000, 32'(seq)};
            seq++;
            bus.disp_valid[i] = 1'b1;
            bus.disp_payload[i*PAY_W +: PAY_W] = p;
            bus.disp_killmask[i*SPEC_W +: SPEC_W] = km;
            bus.disp_exc[i] = ex;
            bus.disp_ecause[i*ECW +: ECW] = ec;
            if (acc) exp_q.push_back(p);
        end
        if (acc) begin
            m_used += n;
            m_tail = (m_tail + n) % DEPTH;
        end
    endtask

    task automatic wake(input int port, input int idx,
                        input logic ex, input logic [ECW-1:0] ec);
        bus.wk_valid[port] = 1'b1;
        bus.wk_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
        bus.wk_exc[port] = ex;
        bus.wk_ecause[port*ECW +: ECW] = ec;
    endtask

    task automatic test_reset();
        logic [DISP_W*IDX_W-1:0] ei;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < DISP_W; i++) ei[i*IDX_W +: IDX_W] = IDX_W'(i);
        n_checks++;
        if (bus.used_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_used: got %0d want 0", bus.used_cnt);
        end
        n_checks++;
        if (bus.free_cnt !== 6'd32) begin
            n_fail++;
            $display("FAIL reset_free: got %0d want 32", bus.free_cnt);
        end
        n_checks++;
        if (bus.disp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.disp_ready);
        end
        n_checks++;
        if (bus.disp_idx !== ei) begin
            n_fail++;
            $display("FAIL reset_idx: got %h want %h", bus.disp_idx, ei);
        end
        n_checks++;
        if (bus.ret_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rv: got %b want 0000", bus.ret_valid);
        end
    endtask

    task automatic test_fill();
        logic [DISP_W*IDX_W-1:0] ei;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < DISP_W; i++)
                ei[i*IDX_W +: IDX_W] = IDX_W'(m_tail + i);
            drive_disp(4, 4'b0000, 1'b0, '0, 1'b1);
            #1;
            n_checks++;
            if (bus.disp_idx !== ei) begin
                n_fail++;
                $display("FAIL fill_idx c%0d: got %h want %h", c, bus.disp_idx, ei);
            end
            tick();
            idle();
        end
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd32 || bus.free_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL full_cnt: got used %0d free %0d want 32/0",
                     bus.used_cnt, bus.free_cnt);
        end
        n_checks++;
        if (bus.disp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b want 0", bus.disp_ready);
        end
        drive_disp(4, 4'b0000, 1'b0, '0, 1'b1);
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'(m_used)) begin
            n_fail++;
            $display("FAIL full_drop: got used %0d want %0d", bus.used_cnt, m_used);
        end
    endtask

    task automatic test_retire();
        for (int p = 0; p < 4; p++) wake(p, p, 1'b0, '0);
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.ret_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL retire_rv: got %b want 1111", bus.ret_valid);
        end
        bus.ret_accept = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.ret_payload[k*PAY_W +: PAY_W] !== e) begin
                n_fail++;
                $display("FAIL retire_pay%0d: got %h want %h", k,
                         bus.ret_payload[k*PAY_W +: PAY_W], e);
            end
        end
        m_used -= 4;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.free_cnt !== 6'd4 || bus.disp_ready !== 1'b1 ||
            bus.ret_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL retire_after: got free %0d ready %b rv %b want 4/1/0000",
                     bus.free_cnt, bus.disp_ready, bus.ret_valid);
        end
        bus.ret_accept = 1'b1;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'(m_used)) begin
            n_fail++;
            $display("FAIL retire_noop: got used %0d want %0d", bus.used_cnt, m_used);
        end
    endtask

    task automatic test_exception();
        wake(0, 4, 1'b0, '0);
        wake(1, 6, 1'b0, '0);
        wake(2, 7, 1'b0, '0);
        tick();
        idle();
        wake(0, 5, 1'b1, 5'd2);
        wake(2, 5, 1'b1, 5'd7);
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.ret_valid !== 4'b0011 || bus.ret_exc !== 4'b0010) begin
            n_fail++;
            $display("FAIL exc_rv: got rv %b exc %b want 0011/0010",
                     bus.ret_valid, bus.ret_exc);
        end
        n_checks++;
        if (bus.ret_ecause[ECW +: ECW] !== 5'd2) begin
            n_fail++;
            $display("FAIL exc_cause: got %0d want 2", bus.ret_ecause[ECW +: ECW]);
        end
        wake(0, 5, 1'b1, 5'd9);
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.ret_ecause[ECW +: ECW] !== 5'd2) begin
            n_fail++;
            $display("FAIL exc_sticky: got %0d want 2", bus.ret_ecause[ECW +: ECW]);
        end
        for (int r = 0; r < 2; r++) begin
            bus.ret_accept = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.ret_payload[k*PAY_W +: PAY_W] !== e) begin
                    n_fail++;
                    $display("FAIL exc_pay r%0d k%0d: got %h want %h", r, k,
                             bus.ret_payload[k*PAY_W +: PAY_W], e);
                end
            end
            m_used -= 2;
            tick();
            idle();
            #1;
            if (r == 0) begin
                n_checks++;
                if (bus.ret_valid !== 4'b0011 || bus.ret_exc !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL exc_next: got rv %b exc %b want 0011/0000",
                             bus.ret_valid, bus.ret_exc);
                end
            end
        end
        n_checks++;
        if (bus.used_cnt !== 6'(m_used)) begin
            n_fail++;
            $display("FAIL exc_used: got %0d want %0d", bus.used_cnt, m_used);
        end
    endtask

    task automatic test_bypass();
        logic want;
`ifdef ROB_WAKEUP_BYPASS_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        wake(0, 8, 1'b0, '0);
        #1;
        n_checks++;
        if (bus.ret_valid[0] !== want) begin
            n_fail++;
            $display("FAIL bypass_same: got %b want %b", bus.ret_valid[0], want);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.ret_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL bypass_next: got %b want 0001", bus.ret_valid);
        end
        bus.ret_accept = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.ret_payload[PAY_W-1:0] !== e) begin
            n_fail++;
            $display("FAIL bypass_pay: got %h want %h", bus.ret_payload[PAY_W-1:0], e);
        end
        m_used -= 1;
        tick();
        idle();
    endtask

    task automatic test_drain();
        int n;
        logic [RET_W-1:0] erv;
        for (int b = 9; b < 30; b += 4) begin
            n = (30 - b < 4) ? 30 - b : 4;
            for (int p = 0; p < n; p++) wake(p, b + p, 1'b0, '0);
            tick();
            idle();
            #1;
            erv = RET_W'((1 << n) - 1);
            n_checks++;
            if (bus.ret_valid !== erv) begin
                n_fail++;
                $display("FAIL drain_rv b%0d: got %b want %b", b, bus.ret_valid, erv);
            end
            bus.ret_accept = 1'b1;
            #1;
            for (int k = 0; k < n; k++) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.ret_payload[k*PAY_W +: PAY_W] !== e) begin
                    n_fail++;
                    $display("FAIL drain_pay b%0d k%0d: got %h want %h", b, k,
                             bus.ret_payload[k*PAY_W +: PAY_W], e);
                end
            end
            m_used -= n;
            tick();
            idle();
        end
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL drain_used: got %0d want 2", bus.used_cnt);
        end
    endtask

    task automatic test_mispredict();
        drive_disp(2, 4'b0001, 1'b0, '0, 1'b1);
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd4) begin
            n_fail++;
            $display("FAIL mp_before: got used %0d want 4", bus.used_cnt);
        end
        bus.br_valid   = 1'b1;
        bus.br_mispred = 1'b1;
        bus.br_tag     = 4'b0001;
        bus.br_idx     = 5'd31;
        drive_disp(4, 4'b0000, 1'b0, '0, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        m_used = 2;
        m_tail = 0;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd2 || bus.disp_idx[IDX_W-1:0] !== 5'd0) begin
            n_fail++;
            $display("FAIL mp_tail: got used %0d tail %0d want 2/0",
                     bus.used_cnt, bus.disp_idx[IDX_W-1:0]);
        end
        wake(0, 30, 1'b0, '0);
        wake(1, 31, 1'b0, '0);
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.ret_valid !== 4'b0011) begin
            n_fail++;
            $display("FAIL mp_rv: got %b want 0011", bus.ret_valid);
        end
        bus.ret_accept = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.ret_payload[k*PAY_W +: PAY_W] !== e) begin
                n_fail++;
                $display("FAIL mp_pay%0d: got %h want %h", k,
                         bus.ret_payload[k*PAY_W +: PAY_W], e);
            end
        end
        m_used -= 2;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL mp_empty: got used %0d want 0", bus.used_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            drive_disp(4, 4'b0000, 1'b1, 5'd5, 1'b1);
            tick();
            idle();
        end
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd28 || bus.ret_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL b2b_fill: got used %0d rv %b want 28/0001",
                     bus.used_cnt, bus.ret_valid);
        end
        n_checks++;
        if (bus.ret_exc[0] !== 1'b1 || bus.ret_ecause[ECW-1:0] !== 5'd5) begin
            n_fail++;
            $display("FAIL b2b_exc: got exc %b cause %0d want 1/5",
                     bus.ret_exc[0], bus.ret_ecause[ECW-1:0]);
        end
        for (int r = 0; r < 2; r++) begin
            drive_disp(4, 4'b0000, 1'b1, 5'd5, 1'b1);
            bus.ret_accept = 1'b1;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.ret_payload[PAY_W-1:0] !== e) begin
                n_fail++;
                $display("FAIL b2b_pay r%0d: got %h want %h", r,
                         bus.ret_payload[PAY_W-1:0], e);
            end
            m_used -= 1;
            tick();
            idle();
            #1;
            n_checks++;
            if (bus.used_cnt !== 6'(m_used) || bus.disp_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_cnt r%0d: got used %0d ready %b want %0d/0", r,
                         bus.used_cnt, bus.disp_ready, m_used);
            end
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive_disp(4, 4'b0000, 1'b0, '0, 1'b0);
        bus.ret_accept = 1'b1;
        tick();
        idle();
        exp_q.delete();
        m_used = 0;
        m_tail = 0;
        #1;
        n_checks++;
        if (bus.used_cnt !== 6'd0 || bus.free_cnt !== 6'd32 ||
            bus.disp_ready !== 1'b1 || bus.ret_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush: got used %0d free %0d ready %b rv %b want 0/32/1/0000",
                     bus.used_cnt, bus.free_cnt, bus.disp_ready, bus.ret_valid);
        end
        n_checks++;
        if (bus.disp_idx !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
            n_fail++;
            $display("FAIL flush_idx: got %h", bus.disp_idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_retire();
        test_exception();
        test_bypass();
        test_drain();
        test_mispredict();
        test_back_to_back();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_param_gen2.md
ROB_PARAM_GEN2 -- requirements
Module: rob_param_gen2

Interface
REQ-001 SHALL have parameter DEPTH, default 32: entry count; power of two, >=4; IDX_W=log2(DEPTH).
REQ-002 SHALL have parameter DISP_W, default 4: dispatch slots per cycle.
REQ-003 SHALL have parameter RET_W, default 4: retire slots per cycle.
REQ-004 SHALL have parameter WK_PORTS, default 4: wakeup ports.
REQ-005 SHALL have parameter SPEC_W, default 4: speculative tag / killmask width.
REQ-006 SHALL have parameter PAY_W, default 64; ECW, default 5: payload and exception-cause widths.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  synchronous active-high reset.
REQ-009 SHALL have port flush  in  1  clear all entries and pointers.
REQ-010 SHALL have port disp_valid  in  DISP_W  dispatch requests; contiguous from bit 0.
REQ-011 SHALL have port disp_payload  in  DISP_W*PAY_W  per-slot payload.
REQ-012 SHALL have port disp_killmask  in  DISP_W*SPEC_W  per-slot killmask.
REQ-013 SHALL have ports disp_exc  in  DISP_W and disp_ecause  in  DISP_W*ECW  decode-time exception and cause.
REQ-014 SHALL have port disp_ready  out  1  free_cnt>=DISP_W.
REQ-015 SHALL have port disp_idx  out  DISP_W*IDX_W  index assigned to each slot (tail+i, wrapped).
REQ-016 SHALL have ports wk_valid  in  WK_PORTS, wk_idx  in  WK_PORTS*IDX_W, wk_exc  in  WK_PORTS, wk_ecause  in  WK_PORTS*ECW  completion bus.
REQ-017 SHALL have ports br_valid  in  1, br_mispred  in  1, br_tag  in  SPEC_W (one-hot), br_idx  in  IDX_W  branch resolution.
REQ-018 SHALL have ports ret_valid  out  RET_W, ret_payload  out  RET_W*PAY_W, ret_exc  out  RET_W, ret_ecause  out  RET_W*ECW  head window.
REQ-019 SHALL have port ret_accept  in  1  retire all entries flagged in ret_valid this cycle.
REQ-020 SHALL have ports used_cnt, free_cnt  out  IDX_W+1 each  occupancy.

Function
REQ-021 SHALL keep head/tail pointers of IDX_W+1 bits (wrap bit); used_cnt=tail-head mod 2^(IDX_W+1); full at DEPTH, empty at 0, both distinguishable.
REQ-022 SHALL write dispatch when disp_ready & |disp_valid & ~flush & ~(br_valid&br_mispred); else drop; tail advances by popcount(disp_valid).
REQ-023 SHALL write entries valid=1, busy=~disp_exc; disp_exc entries need no wakeup.
REQ-024 SHALL clear busy on matching valid entry at wk_valid; wakeup to invalid entry ignored; wk_exc/wk_ecause recorded only if entry has no exception yet; multiple ports to one entry: lowest port wins.
REQ-025 SHALL drive ret_valid as thermometer prefix of head entries that are valid & ~busy, max RET_W, truncated after first entry with exception (that entry included, last).
REQ-026 SHALL on ret_accept invalidate flagged entries and advance head by popcount(ret_valid) next cycle; ret_accept with ret_valid=0 is a no-op.
REQ-027 SHALL on br_valid&br_mispred invalidate every entry with killmask&br_tag!=0 and set tail to head+((br_idx-head[IDX_W-1:0]) mod DEPTH)+1.
REQ-028 SHALL on br_valid&~br_mispred clear br_tag bits from all killmasks, same cycle's dispatch included.
REQ-029 SHALL mask from ret_valid any head entry being killed this cycle.
REQ-030 SHALL apply priority rst > flush > mispredict > dispatch; retire and wakeup also honoured in mispredict cycle.
REQ-031 SHALL allow retire and dispatch together when full: disp_ready from registered free_cnt only (no same-cycle credit).

Reset
REQ-032 SHALL on rst (and flush) clear all entries, head=tail=0; outputs: used_cnt=0, free_cnt=DEPTH, disp_ready=1, disp_idx={DISP_W-1..0}, ret_valid=0.
REQ-033 SHALL discard any dispatch, wakeup, retire or branch in a rst/flush cycle.

Configuration
REQ-034 SHALL, with ROB_WAKEUP_BYPASS_EN defined, treat entries woken this cycle as ~busy for ret_valid (wakeup-to-retire 0 cycles).
REQ-035 SHALL, without ROB_WAKEUP_BYPASS_EN, compute ret_valid from registered busy only (wakeup-to-retire 1 cycle).

Verification
REQ-036 SHALL cover: after rst, dispatch 4 slots x8 cycles, DEPTH=32 -> used_cnt=32, free_cnt=0, disp_ready=0, next dispatch dropped.
REQ-037 SHALL cover: entries 0-3 woken, ret_accept=1 -> ret_valid=4'b1111, head=4, free_cnt=4, disp_ready=1 next cycle.
REQ-038 SHALL cover: head 30, tail 2 (wrapped), mispredict br_idx=31, br_tag=0001 on entries 0-1 -> tail=0, used_cnt=2.
REQ-039 SHALL cover: entry 1 of 0-3 ready with wk_exc, ecause=2 -> ret_valid=4'b0011, ret_exc[1]=1, ret_ecause[1]=2.
REQ-040 SHALL cover: wakeup idx 0 same cycle as view -> ret_valid[0]=1 with ROB_WAKEUP_BYPASS_EN, 0 then 1 next cycle without.
